// File: rtl/updown_count_tracker.sv
// updown_count_tracker
// Watches the output of a 4-bit up/down counter and builds a wider absolute
// position from it. Each edge it also reports the kind of step seen (hold,
// wrap, illegal jump, wrong direction) and keeps a sticky, saturating record
// of errors. Every output comes straight from a register.

module updown_count_tracker #(
  parameter int HI_W  = 8,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_rst,
  input  logic [3:0]        q_in,
  input  logic              up_down,
  input  logic              clr_err,
  output logic              valid,
  output logic [HI_W+3:0]   ext_count,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic              hold,
  output logic              step_err,
  output logic              dir_err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_cnt
);

  // SYNC: adopt the counter's current value as the new reference.
  // TRACK: follow it step by step.
  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Previous sample of the counter and of its direction control
  logic [3:0]       qPrev_q;
  logic             dirPrev_q;

  // Position: upper field counts wraps, low nibble mirrors the counter
  logic [HI_W-1:0]  upper_q,  upper_d;
  logic [3:0]       low_q,    low_d;

  // Registered status flags
  logic             valid_q,   valid_d;
  logic             wrapUp_q,  wrapUp_d;
  logic             wrapDn_q,  wrapDn_d;
  logic             hold_q,    hold_d;
  logic             stepErr_q, stepErr_d;
  logic             dirErr_q,  dirErr_d;
  logic             sticky_q,  sticky_d;
  logic [ERR_W-1:0] errCnt_q,  errCnt_d;

  // How the counter moved since the last sample
  logic [3:0]       delta;
  logic             isHold;
  logic             isUp;
  logic             isDown;
  logic             isJump;
  logic             errEvent;
  logic             errSat;

  // State register. Reset always puts the tracker back into SYNC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A counter reset forces a resync from any state. Otherwise
  // SYNC needs only one sample before tracking begins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC: begin
        if (cnt_rst) begin
          state_d = SYNC;
        end else begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (cnt_rst) begin
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Classify the step as a modulo-16 difference, so that 15->0 counts as +1
  // and 0->15 counts as -1.
  always_comb begin
    delta  = q_in - qPrev_q;
    isHold = (delta == 4'd0);
    isUp   = (delta == 4'd1);
    isDown = (delta == 4'hF);
    isJump = !(isHold || isUp || isDown);
  end

  // Output logic. Works out the next position and the step flags from the
  // current state. During a counter reset the position is re-based at zero,
  // and the error and wrap flags are held off so the reset is not reported
  // as a fault.
  always_comb begin
    upper_d   = upper_q;
    low_d     = q_in;
    valid_d   = 1'b0;
    wrapUp_d  = 1'b0;
    wrapDn_d  = 1'b0;
    hold_d    = 1'b0;
    stepErr_d = 1'b0;
    dirErr_d  = 1'b0;
    case (state_q)
      SYNC: begin
        upper_d = '0;
      end
      TRACK: begin
        hold_d = isHold;
        if (cnt_rst) begin
          upper_d = '0;
        end else begin
          valid_d = 1'b1;
          if (isUp) begin
            if (qPrev_q == 4'hF) begin
              wrapUp_d = 1'b1;
              upper_d  = upper_q + HI_W'(1);
            end
            dirErr_d = dirPrev_q;
          end else if (isDown) begin
            if (qPrev_q == 4'h0) begin
              wrapDn_d = 1'b1;
              upper_d  = upper_q - HI_W'(1);
            end
            dirErr_d = !dirPrev_q;
          end else if (isJump) begin
            stepErr_d = 1'b1;
          end
        end
      end
      default: begin
        upper_d = '0;
      end
    endcase
  end

  // Error bookkeeping. A clear request that lands in the same cycle as a new
  // error still records that error, so the count restarts at one.
  always_comb begin
    errEvent = stepErr_d | dirErr_d;
    errSat   = &errCnt_q;
    sticky_d = sticky_q;
    errCnt_d = errCnt_q;
    if (clr_err) begin
      sticky_d = errEvent;
      errCnt_d = errEvent ? ERR_W'(1) : '0;
    end else if (errEvent) begin
      sticky_d = 1'b1;
      if (!errSat) begin
        errCnt_d = errCnt_q + ERR_W'(1);
      end
    end
  end

  // Datapath registers. The previous-sample registers update on every cycle
  // outside reset, whatever the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      qPrev_q   <= '0;
      dirPrev_q <= 1'b0;
      upper_q   <= '0;
      low_q     <= '0;
      valid_q   <= 1'b0;
      wrapUp_q  <= 1'b0;
      wrapDn_q  <= 1'b0;
      hold_q    <= 1'b0;
      stepErr_q <= 1'b0;
      dirErr_q  <= 1'b0;
      sticky_q  <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      qPrev_q   <= q_in;
      dirPrev_q <= up_down;
      upper_q   <= upper_d;
      low_q     <= low_d;
      valid_q   <= valid_d;
      wrapUp_q  <= wrapUp_d;
      wrapDn_q  <= wrapDn_d;
      hold_q    <= hold_d;
      stepErr_q <= stepErr_d;
      dirErr_q  <= dirErr_d;
      sticky_q  <= sticky_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign valid      = valid_q;
  assign ext_count  = {upper_q, low_q};
  assign wrap_up    = wrapUp_q;
  assign wrap_dn    = wrapDn_q;
  assign hold       = hold_q;
  assign step_err   = stepErr_q;
  assign dir_err    = dirErr_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = errCnt_q;

endmodule

// File: tb/tb_updown_count_tracker.sv
// Testbench for updown_count_tracker. A behavioural model treats the position
// as a plain 12-bit number that moves by +/-1 on legal steps, and a compare
// process checks every output against it on each falling edge. Directed
// sequences add hand-computed literal checks that pin the model itself.

module tb_updown_count_tracker;

  localparam int HI_W  = 8;
  localparam int ERR_W = 8;
  localparam int EXT_W = HI_W + 4;

  logic             clk;
  logic             rst;
  logic             cntRst;
  logic [3:0]       qIn;
  logic             upDown;
  logic             clrErr;
  logic             valid;
  logic [EXT_W-1:0] extCount;
  logic             wrapUp;
  logic             wrapDn;
  logic             hold;
  logic             stepErr;
  logic             dirErr;
  logic             errSticky;
  logic [ERR_W-1:0] errCnt;

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  // Model state and the outputs it expects
  bit               mTrack;
  logic [3:0]       mPrevQ;
  logic             mPrevDir;
  logic [3:0]       mDelta;
  logic [EXT_W-1:0] mNext;
  logic             mEvent;
  logic             eValid;
  logic [EXT_W-1:0] eExt;
  logic             eWrapUp;
  logic             eWrapDn;
  logic             eHold;
  logic             eStepErr;
  logic             eDirErr;
  logic             eSticky;
  int               eCnt;

  updown_count_tracker #(
    .HI_W  (HI_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_rst    (cntRst),
    .q_in       (qIn),
    .up_down    (upDown),
    .clr_err    (clrErr),
    .valid      (valid),
    .ext_count  (extCount),
    .wrap_up    (wrapUp),
    .wrap_dn    (wrapDn),
    .hold       (hold),
    .step_err   (stepErr),
    .dir_err    (dirErr),
    .err_sticky (errSticky),
    .err_cnt    (errCnt)
  );

  // Free-running clock with a 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upper bound on run time
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] run did not finish");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit c, input logic [3:0] q, input bit ud, input bit clr);
    rst    = r;
    cntRst = c;
    qIn    = q;
    upDown = ud;
    clrErr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic resync(input logic [3:0] q, input bit ud);
    applyStimulus(1'b1, 1'b1, q, ud, 1'b0);
    applyStimulus(1'b1, 1'b0, q, ud, 1'b0);
    applyStimulus(1'b1, 1'b0, q, ud, 1'b0);
  endtask

  // Behavioural model: the position is a 12-bit number that moves by exactly
  // one on legal steps. A wrap is a carry or borrow out of the low nibble.
  // A jump keeps the upper field and adopts the new nibble.
  always @(posedge clk) begin
    eWrapUp  = 1'b0;
    eWrapDn  = 1'b0;
    eHold    = 1'b0;
    eStepErr = 1'b0;
    eDirErr  = 1'b0;
    if (!rst) begin
      mTrack   = 1'b0;
      mPrevQ   = '0;
      mPrevDir = 1'b0;
      eValid   = 1'b0;
      eExt     = '0;
      eSticky  = 1'b0;
      eCnt     = 0;
    end else begin
      mDelta = qIn - mPrevQ;
      eHold  = mTrack && (mDelta == 4'd0);
      if (!mTrack || cntRst) begin
        eValid = 1'b0;
        eExt   = {{HI_W{1'b0}}, qIn};
      end else begin
        eValid = 1'b1;
        if (mDelta == 4'd1) begin
          mNext   = eExt + 1'b1;
          eWrapUp = (mNext[EXT_W-1:4] != eExt[EXT_W-1:4]);
          eDirErr = (mPrevDir == 1'b1);
          eExt    = mNext;
        end else if (mDelta == 4'd15) begin
          mNext   = eExt - 1'b1;
          eWrapDn = (mNext[EXT_W-1:4] != eExt[EXT_W-1:4]);
          eDirErr = (mPrevDir == 1'b0);
          eExt    = mNext;
        end else if (mDelta != 4'd0) begin
          eStepErr = 1'b1;
          eExt     = {eExt[EXT_W-1:4], qIn};
        end
      end
      mEvent = eStepErr || eDirErr;
      if (clrErr) begin
        eSticky = mEvent;
        eCnt    = mEvent ? 1 : 0;
      end else if (mEvent) begin
        eSticky = 1'b1;
        if (eCnt < (1 << ERR_W) - 1) eCnt = eCnt + 1;
      end
      mTrack   = !cntRst;
      mPrevQ   = qIn;
      mPrevDir = upDown;
    end
  end

  // Compare process: every output against the model on each falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("valid",      32'(valid),     32'(eValid));
      checkOutput("ext_count",  32'(extCount),  32'(eExt));
      checkOutput("wrap_up",    32'(wrapUp),    32'(eWrapUp));
      checkOutput("wrap_dn",    32'(wrapDn),    32'(eWrapDn));
      checkOutput("hold",       32'(hold),      32'(eHold));
      checkOutput("step_err",   32'(stepErr),   32'(eStepErr));
      checkOutput("dir_err",    32'(dirErr),    32'(eDirErr));
      checkOutput("err_sticky", 32'(errSticky), 32'(eSticky));
      checkOutput("err_cnt",    32'(errCnt),    32'(eCnt));
    end
  end

  // Directed scenarios with literal expectations
  initial begin
    rst = 1'b0; cntRst = 1'b0; qIn = 4'hA; upDown = 1'b0; clrErr = 1'b0;

    // Reset held for two edges, then released
    applyStimulus(1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    checkOutput("lit_reset_valid", 32'(valid), 32'd0);
    checkOutput("lit_reset_ext", 32'(extCount), 32'h000);
    checkOutput("lit_reset_cnt", 32'(errCnt), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
    checkOutput("lit_sync_valid", 32'(valid), 32'd0);
    checkOutput("lit_sync_ext", 32'(extCount), 32'h00A);
    applyStimulus(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
    checkOutput("lit_track_valid", 32'(valid), 32'd1);
    checkOutput("lit_track_ext", 32'(extCount), 32'h00A);
    checkOutput("lit_track_hold", 32'(hold), 32'd1);

    // Up wrap from a fresh sync at zero
    resync(4'h0, 1'b0);
    for (int i = 1; i <= 15; i++) applyStimulus(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
    checkOutput("lit_up_ext_f", 32'(extCount), 32'h00F);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("lit_wrap_up", 32'(wrapUp), 32'd1);
    checkOutput("lit_wrap_up_ext", 32'(extCount), 32'h010);
    applyStimulus(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    checkOutput("lit_wrap_up_clear", 32'(wrapUp), 32'd0);
    checkOutput("lit_up_ext_11", 32'(extCount), 32'h011);
    checkOutput("lit_up_sticky", 32'(errSticky), 32'd0);

    // Turn the direction around (one hold cycle), then count down through zero twice
    applyStimulus(1'b1, 1'b0, 4'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("lit_dn_ext_10", 32'(extCount), 32'h010);
    applyStimulus(1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
    checkOutput("lit_wrap_dn", 32'(wrapDn), 32'd1);
    checkOutput("lit_wrap_dn_ext", 32'(extCount), 32'h00F);
    applyStimulus(1'b1, 1'b0, 4'hE, 1'b1, 1'b0);
    checkOutput("lit_dn_ext_e", 32'(extCount), 32'h00E);
    for (int i = 13; i >= 0; i--) applyStimulus(1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
    checkOutput("lit_upper_wrap_ext", 32'(extCount), 32'hFFF);
    checkOutput("lit_upper_wrap_dn", 32'(wrapDn), 32'd1);
    for (int i = 14; i >= 3; i--) applyStimulus(1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
    checkOutput("lit_dn_ext_ff3", 32'(extCount), 32'hFF3);

    // Illegal jump 3 -> 9
    applyStimulus(1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
    checkOutput("lit_jump_step_err", 32'(stepErr), 32'd1);
    checkOutput("lit_jump_ext", 32'(extCount), 32'hFF9);
    checkOutput("lit_jump_sticky", 32'(errSticky), 32'd1);
    checkOutput("lit_jump_cnt", 32'(errCnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
    checkOutput("lit_jump_pulse_end", 32'(stepErr), 32'd0);

    // Direction mismatch 5 -> 6 while commanded down
    for (int i = 8; i >= 5; i--) applyStimulus(1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h6, 1'b1, 1'b0);
    checkOutput("lit_dir_err", 32'(dirErr), 32'd1);
    checkOutput("lit_dir_cnt", 32'(errCnt), 32'd2);
    checkOutput("lit_dir_ext", 32'(extCount), 32'hFF6);

    // Clear with no error, then a clear that coincides with a 2 -> 7 jump
    applyStimulus(1'b1, 1'b0, 4'h6, 1'b1, 1'b1);
    checkOutput("lit_clr_sticky", 32'(errSticky), 32'd0);
    checkOutput("lit_clr_cnt", 32'(errCnt), 32'd0);
    for (int i = 5; i >= 2; i--) applyStimulus(1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h7, 1'b1, 1'b1);
    checkOutput("lit_clr_ev_sticky", 32'(errSticky), 32'd1);
    checkOutput("lit_clr_ev_cnt", 32'(errCnt), 32'd1);
    checkOutput("lit_clr_ev_step", 32'(stepErr), 32'd1);

    // Counter reset in mid-count at position 0x035
    resync(4'h0, 1'b0);
    for (int i = 1; i <= 53; i++) applyStimulus(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
    checkOutput("lit_pre_cntrst_ext", 32'(extCount), 32'h035);
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    checkOutput("lit_cntrst_step", 32'(stepErr), 32'd0);
    checkOutput("lit_cntrst_valid", 32'(valid), 32'd0);
    checkOutput("lit_cntrst_cnt", 32'(errCnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("lit_post_cntrst_valid", 32'(valid), 32'd1);
    checkOutput("lit_post_cntrst_ext", 32'(extCount), 32'h000);

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? 4'h8 : 4'h0, 1'b0, 1'b0);
    checkOutput("lit_sat_cnt", 32'(errCnt), 32'd255);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("lit_sat_clr", 32'(errCnt), 32'd0);

    // Wrap and direction error on the same step
    resync(4'hF, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("lit_combo_wrap", 32'(wrapUp), 32'd1);
    checkOutput("lit_combo_dir", 32'(dirErr), 32'd1);
    checkOutput("lit_combo_ext", 32'(extCount), 32'h010);

    // Reset in the middle of operation wins over everything
    applyStimulus(1'b0, 1'b1, 4'h5, 1'b0, 1'b1);
    checkOutput("lit_rst2_ext", 32'(extCount), 32'h000);
    checkOutput("lit_rst2_sticky", 32'(errSticky), 32'd0);
    checkOutput("lit_rst2_valid", 32'(valid), 32'd0);

    @(negedge clk);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/updown_count_tracker.md
Name: updown_count_tracker

Overview:
- Downstream monitor for the 4-bit up/down counter.
- Samples the counter output and direction control every clock, and extends the 4-bit value into a wider absolute position by tracking wrap-arounds.
- Flags illegal steps (jumps other than ±1) and steps that contradict the commanded direction.
- Gives the system a wide position value plus health status without widening the counter itself.

Parameters:
- HI_W, 8, width of the wrap-tracking upper field; ext_count is HI_W+4 bits.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset; one clock domain.
- cnt_rst  input  1  copy of the counter's own active-high reset; resynchronises the tracker.
- q_in  input  4  counter output q.
- up_down  input  1  counter direction control, same signal that drives the counter; 0 = count up, 1 = count down.
- clr_err  input  1  single-cycle request to clear err_sticky and err_cnt.
- valid  output  1  ext_count and step flags are meaningful.
- ext_count  output  HI_W+4  {upper, low nibble} absolute position.
- wrap_up  output  1  one-cycle pulse: 15->0 step seen.
- wrap_dn  output  1  one-cycle pulse: 0->15 step seen.
- hold  output  1  one-cycle pulse: q_in unchanged from previous sample.
- step_err  output  1  one-cycle pulse: q_in moved by other than ±1 (mod 16).
- dir_err  output  1  one-cycle pulse: legal step opposite to registered direction.
- err_sticky  output  1  set by any step_err/dir_err; held until clr_err or reset.
- err_cnt  output  ERR_W  saturating count of error events.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs go to 0: valid, ext_count, all pulses, err_sticky, err_cnt.
  - FSM enters SYNC.
  - Internal q_prev and dir_prev are cleared.
  - Reset wins over every other input.
- Internal registers: q_prev[3:0] and dir_prev, updated every cycle outside reset with q_in and up_down.
- FSM states: SYNC, TRACK.
- SYNC:
  - Capture q_prev <= q_in; upper <= 0; ext_count <= {0, q_in}.
  - valid stays 0; no pulses.
  - Next state is TRACK unless cnt_rst=1.
- TRACK: each cycle compute d = (q_in - q_prev) mod 16.
  - d=0: hold=1; ext_count unchanged.
  - d=1: up step.
    - If q_prev=15: wrap_up=1 and upper <= upper+1, modulo 2^HI_W with silent wrap.
    - If dir_prev=1: dir_err=1.
  - d=15: down step.
    - If q_prev=0: wrap_dn=1 and upper <= upper-1, modulo 2^HI_W.
    - If dir_prev=0: dir_err=1.
  - Any other d: step_err=1; upper unchanged (tracker resyncs to the new value).
  - In all cases the low nibble of ext_count <= q_in and valid=1.
- cnt_rst=1 in any state:
  - Next state is SYNC; upper <= 0; valid <= 0 on the following edge.
  - Suppresses step_err, dir_err and wrap pulses for that cycle, so a counter reset is not an error.
- Latency: every output is registered. A q_in change sampled at edge N is visible on outputs after edge N.
- Pulses are high for exactly one cycle per event; they are mutually exclusive except that dir_err may accompany wrap_up/wrap_dn.
- Error accounting: err_event = step_err | dir_err.
  - err_event sets err_sticky and increments err_cnt, saturating at 2^ERR_W-1 with no wrap.
  - clr_err=1 alone: err_sticky <= 0, err_cnt <= 0.
  - clr_err=1 coinciding with err_event: err_sticky <= 1, err_cnt <= 1.

Test Plan:
- Reset: rst=0 for 2 cycles with q_in=4'hA, then release -> all outputs 0; one cycle later valid=1, ext_count=12'h00A.
- Up wrap: after sync at q_in=0, drive q_in 1..15,0,1 with up_down=0 -> wrap_up one pulse on the 15->0 step; ext_count ends 12'h011; no error flags.
- Down wrap: from ext_count=12'h011, drive up_down=1 with q_in 0,15,14 -> wrap_dn one pulse on 0->15; ext_count=12'h00E; then continue down past 0 again -> ext_count=12'hFFF region, upper wraps to 8'hFF.
- Illegal jump: q_in 3 -> 9 -> step_err=1 for one cycle, err_sticky=1, err_cnt=1, ext_count low nibble=9, upper unchanged.
- Direction mismatch and clear: up_down=1 held while q_in steps 5->6 -> dir_err=1, err_cnt increments. Next, clr_err=1 with no error -> err_sticky=0, err_cnt=0. Then clr_err=1 together with a 2->7 jump -> err_sticky=1, err_cnt=1.
- Counter reset mid-count: ext_count=12'h035, cnt_rst=1 with q_in forced to 0 -> no step_err; valid=0 for one cycle; then ext_count=12'h000, valid=1.
